lcd_dma_axi_reader: RTL and testbench

- Upstream DMA engine for the LCD frame FIFO.
- Turns each single-cycle DMA_START/DMA_RD_ADDR request from the FIFO into one fixed-length AXI3 read burst on a 32-bit HP port.
- Forwards each returned beat to the FIFO as DMA_RD_DATA with a one-cycle DMA_RD_DATA_VALID strobe.
- Lives in the CLK domain next to the FIFO's write side.

---
 rtl/lcd_dma_axi_reader.sv | 83 ++++++++
 tb/tb_lcd_dma_axi_reader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_dma_axi_reader.sv
// lcd_dma_axi_reader: turns DMA_START requests into fixed-length AXI3 read bursts and forwards beats to the LCD FIFO.
// Optional response/RLAST/alignment checking is enabled by defining LCD_DMA_AXI_CHECK_EN.
module lcd_dma_axi_reader #(
  parameter int         BURST_LEN = 8,
  parameter logic [3:0] AXI_CACHE = 4'b0011
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [28:0] DMA_RD_ADDR,
  input  logic        DMA_START,
  output logic        DMA_READY,
  output logic [31:0] DMA_RD_DATA,
  output logic        DMA_RD_DATA_VALID,
  output logic        DMA_ERROR,
  output logic [31:0] M_AXI_ARADDR,
  output logic [3:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic [3:0]  M_AXI_ARCACHE,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_next;
  logic [3:0] cnt;
  logic start, beat, last;
  assign start = state == IDLE && DMA_START;
  assign beat = state == DATA && M_AXI_RVALID;
  assign last = cnt == 4'(BURST_LEN - 1);
  assign DMA_READY = state == IDLE;
  assign M_AXI_ARVALID = state == ADDR;
  assign M_AXI_RREADY = state == DATA;
  assign M_AXI_ARLEN = 4'(BURST_LEN - 1);
  assign M_AXI_ARSIZE = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARCACHE = AXI_CACHE;
  assign M_AXI_ARPROT = 3'b000;
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = DMA_START ? ADDR : IDLE;
      ADDR: state_next = M_AXI_ARREADY ? DATA : ADDR;
      DATA: state_next = (M_AXI_RVALID && last) ? IDLE : DATA;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      M_AXI_ARADDR <= '0;
      DMA_RD_DATA <= '0;
      DMA_RD_DATA_VALID <= 1'b0;
    end else begin
      state <= state_next;
      if (start) M_AXI_ARADDR <= {DMA_RD_ADDR, 3'b000};
      if (state == ADDR && M_AXI_ARREADY) cnt <= '0;
      else if (beat) cnt <= cnt + 4'd1;
      DMA_RD_DATA <= beat ? M_AXI_RDATA : '0;
      DMA_RD_DATA_VALID <= beat;
    end
  end
`ifdef LCD_DMA_AXI_CHECK_EN
  logic err, misalign;
  // a burst of BURST_LEN words must start on a BURST_LEN*4-byte boundary
  assign misalign = ({DMA_RD_ADDR, 3'b000} & 32'(BURST_LEN * 4 - 1)) != '0;
  always_ff @(posedge CLK) begin
    if (RESET) err <= 1'b0;
    else if ((beat && (M_AXI_RRESP != 2'b00 || M_AXI_RLAST != last)) || (start && misalign)) err <= 1'b1;
  end
  assign DMA_ERROR = err;
`else
  logic unused_chk;
  assign unused_chk = ^{M_AXI_RRESP, M_AXI_RLAST};
  assign DMA_ERROR = 1'b0;
`endif
endmodule

// File: tb/tb_lcd_dma_axi_reader.sv
// tb_lcd_dma_axi_reader: directed and randomized bursts against a queue-based reference of the AXI read DMA.
module tb_lcd_dma_axi_reader;
`ifdef LCD_DMA_AXI_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [28:0] DMA_RD_ADDR = '0;
  logic        DMA_START = 1'b0;
  logic        DMA_READY;
  logic [31:0] DMA_RD_DATA;
  logic        DMA_RD_DATA_VALID;
  logic        DMA_ERROR;
  logic [31:0] M_AXI_ARADDR;
  logic [3:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [3:0]  M_AXI_ARCACHE;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = '0;
  logic        M_AXI_RLAST = 1'b0;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;

  lcd_dma_axi_reader dut (
    .CLK(CLK), .RESET(RESET), .DMA_RD_ADDR(DMA_RD_ADDR), .DMA_START(DMA_START),
    .DMA_READY(DMA_READY), .DMA_RD_DATA(DMA_RD_DATA), .DMA_RD_DATA_VALID(DMA_RD_DATA_VALID),
    .DMA_ERROR(DMA_ERROR), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARCACHE(M_AXI_ARCACHE),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int ar_cnt = 0;
  int exp_ar = 0;
  int v_cnt = 0;
  int exp_v = 0;
  bit exp_err = 1'b0;
  logic [31:0] exp_q[$];

  always @(posedge CLK) if (!RESET && M_AXI_ARVALID && M_AXI_ARREADY) ar_cnt++;
  always @(negedge CLK) if (DMA_RD_DATA_VALID) v_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_ready", 32'(DMA_READY), 1);
    check("rst_arvalid", 32'(M_AXI_ARVALID), 0);
    check("rst_rready", 32'(M_AXI_RREADY), 0);
    check("rst_valid", 32'(DMA_RD_DATA_VALID), 0);
    check("rst_data", DMA_RD_DATA, 0);
    check("rst_error", 32'(DMA_ERROR), 0);
    check("rst_araddr", M_AXI_ARADDR, 0);
  endtask

  // gap_mode: 0 none, 1 three idle cycles before beat 3, 2 random
  task automatic run_burst(input logic [28:0] a, input int ar_delay, input int gap_mode,
                           input bit rand_data, input int rst_after, input bit stray,
                           input int bad_resp, input int bad_last);
    logic [31:0] d;
    int g;
    check("idle_ready", 32'(DMA_READY), 1);
    DMA_RD_ADDR = a;
    DMA_START = 1'b1;
    if (CHK && a[1:0] != 2'b00) exp_err = 1'b1;
    @(negedge CLK);
    DMA_START = 1'b0;
    check("ar_valid", 32'(M_AXI_ARVALID), 1);
    check("ar_addr", M_AXI_ARADDR, {a, 3'b000});
    check("busy_ready", 32'(DMA_READY), 0);
    for (int k = 0; k < ar_delay; k++) begin
      @(negedge CLK);
      check("stall_arvalid", 32'(M_AXI_ARVALID), 1);
      check("stall_araddr", M_AXI_ARADDR, {a, 3'b000});
      check("stall_ready", 32'(DMA_READY), 0);
    end
    M_AXI_ARREADY = 1'b1;
    @(negedge CLK);
    M_AXI_ARREADY = 1'b0;
    exp_ar++;
    check("ar_drop", 32'(M_AXI_ARVALID), 0);
    check("rready_on", 32'(M_AXI_RREADY), 1);
    for (int i = 0; i < 8; i++) begin
      g = gap_mode == 1 ? (i == 3 ? 3 : 0) :
          gap_mode == 2 ? ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) : 0;
      M_AXI_RVALID = 1'b0;
      for (int k = 0; k < g; k++) begin
        @(negedge CLK);
        check("gap_valid", 32'(DMA_RD_DATA_VALID), 0);
        check("gap_data", DMA_RD_DATA, 0);
      end
      d = rand_data ? $urandom : 32'(i);
      exp_q.push_back(d);
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA = d;
      M_AXI_RRESP = i == bad_resp ? 2'b10 : 2'b00;
      M_AXI_RLAST = (i == 7) ^ (i == bad_last);
      if (CHK && (i == bad_resp || i == bad_last)) exp_err = 1'b1;
      if (stray && i == 3) begin
        DMA_START = 1'b1;
        DMA_RD_ADDR = 29'h10000004;
      end
      @(negedge CLK);
      DMA_START = 1'b0;
      exp_v++;
      check("beat_valid", 32'(DMA_RD_DATA_VALID), 1);
      check("beat_data", DMA_RD_DATA, exp_q.pop_front());
      check("beat_ready", 32'(DMA_READY), 32'(i == 7));
      check("beat_rready", 32'(M_AXI_RREADY), 32'(i != 7));
      check("beat_noar", 32'(M_AXI_ARVALID), 0);
      check("beat_araddr", M_AXI_ARADDR, {a, 3'b000});
      if (i == rst_after) begin
        M_AXI_RVALID = 1'b0;
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        exp_err = 1'b0;
        check_reset_state();
        return;
      end
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST = 1'b0;
    M_AXI_RRESP = 2'b00;
    @(negedge CLK);
    check("end_valid", 32'(DMA_RD_DATA_VALID), 0);
    check("end_data", DMA_RD_DATA, 0);
    check("end_ready", 32'(DMA_READY), 1);
    check("end_rready", 32'(M_AXI_RREADY), 0);
    check("end_error", 32'(DMA_ERROR), 32'(exp_err));
    check("ar_count", 32'(ar_cnt), 32'(exp_ar));
    check("beat_count", 32'(v_cnt), 32'(exp_v));
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    check_reset_state();
    check("arlen", 32'(M_AXI_ARLEN), 7);
    check("arsize", 32'(M_AXI_ARSIZE), 2);
    check("arburst", 32'(M_AXI_ARBURST), 1);
    check("arcache", 32'(M_AXI_ARCACHE), 3);
    check("arprot", 32'(M_AXI_ARPROT), 0);
    run_burst(29'h10000000, 0, 0, 1'b0, -1, 1'b0, -1, -1);
    run_burst(29'h00000100, 5, 0, 1'b1, -1, 1'b0, -1, -1);
    run_burst(29'h00000200, 1, 1, 1'b0, -1, 1'b0, -1, -1);
    run_burst(29'h00000300, 0, 2, 1'b1, -1, 1'b1, -1, -1);
    run_burst(29'h00000400, 2, 0, 1'b1, 4, 1'b0, -1, -1);
    run_burst(29'h00000500, 0, 0, 1'b0, -1, 1'b0, -1, -1);
    run_burst(29'h00000600, 0, 0, 1'b1, -1, 1'b0, 5, -1);
    run_burst(29'h00000700, 1, 2, 1'b1, -1, 1'b0, -1, -1);
    check("err_sticky", 32'(DMA_ERROR), 32'(CHK));
    run_burst(29'h00000800, 0, 0, 1'b1, 7, 1'b0, -1, -1);
    run_burst(29'h00000900, 0, 0, 1'b1, -1, 1'b0, -1, 6);
    run_burst(29'h00000a00, 0, 0, 1'b1, 7, 1'b0, -1, -1);
    run_burst(29'h00000b00, 0, 0, 1'b1, -1, 1'b0, -1, 7);
    run_burst(29'h00000c00, 0, 0, 1'b1, 7, 1'b0, -1, -1);
    run_burst(29'h00000c01, 0, 0, 1'b1, -1, 1'b0, -1, -1);
    for (int n = 0; n < 40; n++) begin
      logic [28:0] a;
      a = 29'($urandom);
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      run_burst(a, $urandom_range(0, 3), 2, 1'b1,
                $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 7)) : -1,
                1'(($urandom_range(0, 3) == 0)),
                $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 7)) : -1,
                $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 7)) : -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
